// File: rtl/synth_pkg.sv
// Shared types, tuning table and wave shaper for the polyphonic synth core.
package synth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAttack,
        StSustain,
        StRelease
    } voice_state_t;

    typedef enum logic [1:0] {
        WaveSaw    = 2'd0,
        WaveSquare = 2'd1,
        WaveTri    = 2'd2,
        WavePulse  = 2'd3
    } wave_t;

    localparam int unsigned INC_TABLE_LEN = 25;

    // Phase increments for 261.63 Hz upward in semitones at a 46.875 kHz tick.
    localparam logic [15:0] INC_TABLE [INC_TABLE_LEN] = '{
        16'd366,  16'd388,  16'd411,  16'd435,  16'd461,
        16'd488,  16'd517,  16'd548,  16'd581,  16'd615,
        16'd652,  16'd691,  16'd732,  16'd775,  16'd821,
        16'd870,  16'd922,  16'd977,  16'd1035, 16'd1096,
        16'd1161, 16'd1230, 16'd1304, 16'd1381, 16'd1463
    };

    function automatic logic [7:0] wave_shape(input logic [7:0] p, input wave_t sel);
        logic [7:0] dbl;
        logic [7:0] y;
        dbl = {p[6:0], 1'b0};
        y   = p;
        unique case (sel)
            WaveSaw:    y = p;
            WaveSquare: y = p[7] ? 8'hff : 8'h00;
            WaveTri:    y = p[7] ? ~dbl : dbl;
            WavePulse:  y = (p[7:6] == 2'b00) ? 8'hff : 8'h00;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/synth_if.sv
// Key/control inputs and audio outputs of the synth core.
interface synth_if #(
    parameter int unsigned NUM_KEYS   = 13,
    parameter int unsigned NUM_VOICES = 4
);
    logic [NUM_KEYS-1:0]   key;
    logic [1:0]            octave;
    logic [1:0]            wave_sel;
    logic [7:0]            sample;
    logic                  sample_valid;
    logic [NUM_VOICES-1:0] voice_active;

    modport master (
        output key,
        output octave,
        output wave_sel,
        input  sample,
        input  sample_valid,
        input  voice_active
    );

    modport slave (
        input  key,
        input  octave,
        input  wave_sel,
        output sample,
        output sample_valid,
        output voice_active
    );
endinterface

// File: rtl/poly_voice.sv
// One synth voice: phase accumulator, linear attack/release envelope and wave shaper.
module poly_voice
    import synth_pkg::*;
#(
    parameter int unsigned ACC_W        = 16,
    parameter int unsigned ATTACK_STEP  = 16,
    parameter int unsigned RELEASE_STEP = 8
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         tick,
    input  logic         start,
    input  logic         retrig,
    input  logic         rel,
    input  logic [15:0]  inc,
    input  wave_t        wave_sel,
    output voice_state_t state,
    output logic [7:0]   level,
    output logic [7:0]   wave
);

    logic [ACC_W-1:0] phase;
    logic [8:0]       att_sum;
    logic             att_full;
    logic             rel_empty;

    assign att_sum   = {1'b0, level} + 9'(ATTACK_STEP);
    assign att_full  = (att_sum >= 9'd255);
    assign rel_empty = (level <= 8'(RELEASE_STEP));

    // Allocation events win over the envelope step of a coincident tick.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= StIdle;
            level <= '0;
            phase <= '0;
        end else if (start) begin
            state <= StAttack;
            level <= '0;
            phase <= '0;
        end else begin
            if (tick && state != StIdle) begin
                phase <= phase + ACC_W'(inc);
            end
            if (retrig) begin
                state <= StAttack;
            end else if (rel) begin
                state <= StRelease;
            end else if (tick) begin
                unique case (state)
                    StIdle: level <= '0;
                    StAttack: begin
                        if (att_full) begin
                            level <= 8'hff;
                            state <= StSustain;
                        end else begin
                            level <= att_sum[7:0];
                        end
                    end
                    StSustain: ;
                    StRelease: begin
                        if (rel_empty) begin
                            level <= '0;
                            state <= StIdle;
                        end else begin
                            level <= level - 8'(RELEASE_STEP);
                        end
                    end
                endcase
            end
        end
    end

    assign wave = wave_shape(phase[ACC_W-1 -: 8], wave_sel);

endmodule

// File: rtl/poly_synth_core.sv
// Polyphonic synth: key-event allocator, sample prescaler and voice mixer around poly_voice.
module poly_synth_core
    import synth_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = 13,
    parameter int unsigned NUM_VOICES   = 4,
    parameter int unsigned SAMPLE_DIV   = 256,
    parameter int unsigned ACC_W        = 16,
    parameter int unsigned ATTACK_STEP  = 16,
    parameter int unsigned RELEASE_STEP = 8
) (
    input logic clk,
    input logic nRst,
    synth_if.slave bus
);

    localparam int unsigned KEY_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned VOICE_W = $clog2(NUM_VOICES);
    localparam int unsigned CNT_W   = $clog2(SAMPLE_DIV);
    localparam int unsigned MIX_W   = 8 + VOICE_W;

    logic [CNT_W-1:0]      cnt_q;
    logic                  tick;
    logic [NUM_KEYS-1:0]   key_q, key_q_d;
    logic [VOICE_W-1:0]    steal_ptr_q, steal_ptr_d;
    logic [KEY_W-1:0]      owner_q [NUM_VOICES];
    logic [7:0]            sample_q;
    logic                  sample_valid_q;

    logic                  ev_valid, ev_rel;
    logic [KEY_W-1:0]      ev_key;
    logic [NUM_KEYS-1:0]   ev_mask;
    logic                  owned, idle_found;
    logic [VOICE_W-1:0]    own_idx, idle_idx;
    logic [NUM_VOICES-1:0] start_vec, retrig_vec, rel_vec, active;

    voice_state_t          vstate [NUM_VOICES];
    logic [7:0]            vlevel [NUM_VOICES];
    logic [7:0]            vwave  [NUM_VOICES];
    logic [7:0]            vmix   [NUM_VOICES];
    logic [15:0]           vinc   [NUM_VOICES];
    logic [MIX_W-1:0]      mix_sum;

    assign tick = (cnt_q == CNT_W'(SAMPLE_DIV - 1));

    // Releases first, lowest key first; only one event is consumed per cycle.
    always_comb begin
        ev_valid = 1'b0;
        ev_rel   = 1'b0;
        ev_key   = '0;
        ev_mask  = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (key_q[i] && !bus.key[i]) begin
                ev_valid   = 1'b1;
                ev_rel     = 1'b1;
                ev_key     = KEY_W'(i);
                ev_mask    = '0;
                ev_mask[i] = 1'b1;
            end
        end
        if (!ev_valid) begin
            for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
                if (!key_q[i] && bus.key[i]) begin
                    ev_valid   = 1'b1;
                    ev_key     = KEY_W'(i);
                    ev_mask    = '0;
                    ev_mask[i] = 1'b1;
                end
            end
        end
    end

    assign key_q_d = key_q ^ ev_mask;

    always_comb begin
        owned      = 1'b0;
        own_idx    = '0;
        idle_found = 1'b0;
        idle_idx   = '0;
        for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
            if (vstate[v] != StIdle && owner_q[v] == ev_key) begin
                owned   = 1'b1;
                own_idx = VOICE_W'(v);
            end
            if (vstate[v] == StIdle) begin
                idle_found = 1'b1;
                idle_idx   = VOICE_W'(v);
            end
        end
    end

    always_comb begin
        start_vec   = '0;
        retrig_vec  = '0;
        rel_vec     = '0;
        steal_ptr_d = steal_ptr_q;
        if (ev_valid) begin
            if (ev_rel) begin
                if (owned) begin
                    rel_vec[own_idx] = 1'b1;
                end
            end else if (owned) begin
                retrig_vec[own_idx] = 1'b1;
            end else if (idle_found) begin
                start_vec[idle_idx] = 1'b1;
            end else begin
                start_vec[steal_ptr_q] = 1'b1;
                steal_ptr_d            = steal_ptr_q + VOICE_W'(1);
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign vinc[v]   = INC_TABLE[5'(owner_q[v])] >> bus.octave;
        assign vmix[v]   = 8'((16'(vwave[v]) * 16'(vlevel[v])) >> 8);
        assign active[v] = (vstate[v] != StIdle);

        poly_voice #(
            .ACC_W        (ACC_W),
            .ATTACK_STEP  (ATTACK_STEP),
            .RELEASE_STEP (RELEASE_STEP)
        ) u_voice (
            .clk      (clk),
            .nRst     (nRst),
            .tick     (tick),
            .start    (start_vec[v]),
            .retrig   (retrig_vec[v]),
            .rel      (rel_vec[v]),
            .inc      (vinc[v]),
            .wave_sel (wave_t'(bus.wave_sel)),
            .state    (vstate[v]),
            .level    (vlevel[v]),
            .wave     (vwave[v])
        );
    end

    // Each term is at most 254, so the sum fits MIX_W bits and the shift can't overflow.
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            mix_sum = mix_sum + MIX_W'(vmix[v]);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q          <= '0;
            key_q          <= '0;
            steal_ptr_q    <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                owner_q[v] <= '0;
            end
        end else begin
            cnt_q          <= tick ? '0 : cnt_q + CNT_W'(1);
            key_q          <= key_q_d;
            steal_ptr_q    <= steal_ptr_d;
            sample_valid_q <= tick;
            if (tick) begin
                sample_q <= mix_sum[MIX_W-1 -: 8];
            end
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                if (start_vec[v]) begin
                    owner_q[v] <= ev_key;
                end
            end
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.voice_active = active;

endmodule

// File: tb/tb_poly_synth_core.sv
// Directed bench for poly_synth_core with a per-tick sample scoreboard and voice model.
module tb_poly_synth_core;

    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    synth_if #(.NUM_KEYS(13), .NUM_VOICES(4)) bus ();

    poly_synth_core #(
        .NUM_KEYS     (13),
        .NUM_VOICES   (4),
        .SAMPLE_DIV   (256),
        .ACC_W        (16),
        .ATTACK_STEP  (16),
        .RELEASE_STEP (8)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int unsigned sb[$];

    // Voice model: st 0 idle, 1 attack, 2 sustain, 3 release.
    int          m_st  [4];
    int          m_lvl [4];
    logic [15:0] m_ph  [4];
    int          m_key [4];
    int          mcnt;
    logic        last_tick;
    logic        chk_bound;
    logic [1:0]  cur_oct;
    logic [1:0]  cur_wave;
    int unsigned inc_tab [8] = '{366, 388, 411, 435, 461, 488, 517, 548};
    int          guard;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wave_of(input logic [7:0] p, input logic [1:0] sel);
        logic [7:0] d;
        d = {p[6:0], 1'b0};
        case (sel)
            2'd0:    return int'(p);
            2'd1:    return p[7] ? 255 : 0;
            2'd2:    return p[7] ? int'(~d) : int'(d);
            default: return (p[7:6] == 2'b00) ? 255 : 0;
        endcase
    endfunction

    function automatic int unsigned model_mix();
        int s;
        s = 0;
        for (int v = 0; v < 4; v++) begin
            s += (wave_of(m_ph[v][15:8], cur_wave) * m_lvl[v]) >> 8;
        end
        return int'(s >> 2);
    endfunction

    function automatic logic [3:0] exp_active();
        logic [3:0] a;
        for (int v = 0; v < 4; v++) a[v] = (m_st[v] != 0);
        return a;
    endfunction

    task automatic model_tick();
        for (int v = 0; v < 4; v++) begin
            if (m_st[v] != 0) m_ph[v] = m_ph[v] + 16'(inc_tab[m_key[v]] >> cur_oct);
            case (m_st[v])
                1: begin
                    m_lvl[v] += 16;
                    if (m_lvl[v] >= 255) begin
                        m_lvl[v] = 255;
                        m_st[v]  = 2;
                    end
                end
                3: begin
                    m_lvl[v] -= 8;
                    if (m_lvl[v] <= 0) begin
                        m_lvl[v] = 0;
                        m_st[v]  = 0;
                    end
                end
                0: m_lvl[v] = 0;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            m_st[v]  = 0;
            m_lvl[v] = 0;
            m_ph[v]  = '0;
            m_key[v] = 0;
        end
        mcnt      = 0;
        last_tick = 1'b0;
    endtask

    task automatic model_start(input int v, input int k);
        m_st[v]  = 1;
        m_lvl[v] = 0;
        m_ph[v]  = '0;
        m_key[v] = k;
    endtask

    task automatic set_ctrl();
        bus.octave   = cur_oct;
        bus.wave_sel = cur_wave;
    endtask

    // One clock: predict, cross the edge, then compare strobe, allocation and scoreboard.
    task automatic step();
        logic tk;
        tk = (mcnt == 255);
        if (tk) begin
            sb.push_back(model_mix());
            model_tick();
            mcnt = 0;
        end else begin
            mcnt++;
        end
        @(posedge clk);
        #1;
        last_tick = tk;
        check("sample_valid", 32'(bus.sample_valid), 32'(tk));
        check("voice_active", 32'(bus.voice_active), 32'(exp_active()));
        if (bus.sample_valid && sb.size() != 0) begin
            check("sample", 32'(bus.sample), sb.pop_front());
            if (chk_bound) check("sample_le_63", 32'(bus.sample <= 8'd63), 32'd1);
        end
        sb.delete();
    endtask

    task automatic run_ticks(input int n);
        repeat (n * 256) step();
    endtask

    // Keep multi-cycle event sequences clear of the tick cycle.
    task automatic sync_safe();
        while (mcnt >= 250) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sample"}, 32'(bus.sample), 32'd0);
        check({tag, "_valid"}, 32'(bus.sample_valid), 32'd0);
        check({tag, "_active"}, 32'(bus.voice_active), 32'd0);
    endtask

    initial begin
        nRst      = 1'b0;
        bus.key   = '0;
        cur_oct   = 2'd0;
        cur_wave  = 2'd0;
        chk_bound = 1'b0;
        set_ctrl();
        model_reset();
        #1;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        nRst = 1'b1;

        repeat (600) step();

        // Single saw voice on key 0.
        chk_bound = 1'b1;
        sync_safe();
        bus.key[0] = 1'b1;
        model_start(0, 0);
        step();
        run_ticks(17);
        chk_bound = 1'b0;

        // Release from sustain, re-press mid-release.
        sync_safe();
        bus.key[0] = 1'b0;
        m_st[0] = 3;
        guard = 0;
        while (m_lvl[0] > 128 && guard < 20000) begin
            step();
            guard++;
        end
        sync_safe();
        bus.key[0] = 1'b1;
        m_st[0] = 1;
        step();
        run_ticks(10);
        sync_safe();
        bus.key[0] = 1'b0;
        m_st[0] = 3;
        run_ticks(34);

        // Five keys at once: four allocations then a steal of voice 0.
        cur_wave = 2'd1;
        set_ctrl();
        sync_safe();
        bus.key[4:0] = 5'h1f;
        model_start(0, 0);
        step();
        model_start(1, 1);
        step();
        model_start(2, 2);
        step();
        model_start(3, 3);
        step();
        model_start(0, 4);
        step();
        run_ticks(3);

        // Release beats press; the press then steals voice 1.
        sync_safe();
        bus.key[4] = 1'b0;
        bus.key[5] = 1'b1;
        m_st[0] = 3;
        step();
        model_start(1, 5);
        step();
        cur_wave = 2'd2;
        cur_oct  = 2'd1;
        set_ctrl();
        run_ticks(3);
        cur_wave = 2'd3;
        cur_oct  = 2'd2;
        set_ctrl();
        run_ticks(3);

        // Release everything; keys 0 and 1 no longer own a voice.
        sync_safe();
        bus.key = '0;
        step();
        step();
        m_st[2] = 3;
        step();
        m_st[3] = 3;
        step();
        m_st[1] = 3;
        step();
        run_ticks(34);

        // Asynchronous reset mid-note, just after a sample strobe.
        cur_wave = 2'd0;
        cur_oct  = 2'd0;
        set_ctrl();
        sync_safe();
        bus.key[7] = 1'b1;
        model_start(0, 7);
        step();
        run_ticks(12);
        guard = 0;
        while (!last_tick && guard < 300) begin
            step();
            guard++;
        end
        #3;
        nRst    = 1'b0;
        bus.key = '0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("held_reset");
        nRst = 1'b1;
        model_reset();
        sb.delete();

        repeat (300) step();
        chk_bound = 1'b1;
        sync_safe();
        bus.key[0] = 1'b1;
        model_start(0, 0);
        step();
        run_ticks(17);
        chk_bound = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/poly_synth_core.md
# poly_synth_core

Polyphonic synthesis core for the keyboard synth. It generalises the fixed one-oscillator-per-key datapath to NUM_VOICES shared voices dynamically allocated across NUM_KEYS keys. Each voice has a phase accumulator, four selectable waveforms, and a linear attack/release envelope. Voices are mixed into one 8-bit sample per sample tick, which feeds the existing PWM stage.

## Interface
- NUM_KEYS, 13, number of key inputs; 1..25 (bounded by tuning table)
- NUM_VOICES, 4, voice slots; power of two, 2..8
- SAMPLE_DIV, 256, clk cycles per sample tick (12 MHz / 256 = 46.875 kHz)
- ACC_W, 16, phase accumulator width
- ATTACK_STEP, 16, envelope increment per tick in ATTACK
- RELEASE_STEP, 8, envelope decrement per tick in RELEASE

- clk  in  1  system clock (12 MHz)
- nRst  in  1  reset; asynchronous, active-low
- key  in  NUM_KEYS  debounced, clk-synchronous key levels; 1 = pressed
- octave  in  2  octave down-shift; phase increment >> octave
- wave_sel  in  2  0 saw, 1 square, 2 triangle, 3 pulse-25%
- sample  out  8  mixed unsigned sample
- sample_valid  out  1  one-cycle strobe when sample updates
- voice_active  out  NUM_VOICES  voice state != IDLE

## Operation
- Key events: key_q holds the last processed level per key. Release event = key_q=1 & key=0; press event = key_q=0 & key=1.
- One event per cycle. Releases take priority over presses; lowest key index first. Only the handled bit of key_q updates, so other events stay pending.
- Release: the voice owning that key goes to RELEASE. If no voice owns it (it was stolen), only key_q updates.
- Press, in priority order:
  - A voice already owns the key (RELEASE): go to ATTACK from the current level; phase is kept.
  - Else, lowest-index IDLE voice.
  - Else, steal the voice at steal_ptr, then steal_ptr = (steal_ptr+1) mod NUM_VOICES.
  - A new or stolen voice gets owner=key, phase=0, level=0, ATTACK.
- Voice states are IDLE, ATTACK, SUSTAIN, RELEASE. On each tick:
  - ATTACK: level += ATTACK_STEP, saturating at 255. Reaching 255 moves to SUSTAIN.
  - SUSTAIN: holds.
  - RELEASE: level -= RELEASE_STEP, saturating at 0. Reaching 0 moves to IDLE.
  - IDLE: level = 0, phase not advanced.
- Phase: on each tick, non-IDLE voices do phase += INC_TABLE[owner] >> octave, wrapping mod 2^ACC_W.
- Waveform uses p = phase[ACC_W-1 -: 8]:
  - saw = p
  - square = p[7] ? 255 : 0
  - triangle = p[7] ? ~(p<<1) : (p<<1), 8-bit
  - pulse = (p[7:6]==0) ? 255 : 0
- Mix: v_i = (wave_i × level_i) >> 8. sum = Σv_i. sample = sum >> log2(NUM_VOICES); it never overflows.

## Timing
- Prescaler counts 0..SAMPLE_DIV-1. tick = (count == SAMPLE_DIV-1).
- On the tick edge:
  - sample loads the mix of pre-update phases and levels.
  - sample_valid is high for the following cycle only.
  - Phases and envelopes update on the same edge.
- First sample_valid occurs in cycle SAMPLE_DIV after reset release.
- Key event to allocation: voice state, owner and voice_active update on the edge after the cycle the event is handled.
- An event handled on a tick cycle overrides that voice's envelope step for that tick; the allocation result is loaded.
- octave and wave_sel changes take effect at the next tick. Phase is not reset.
- Reset values: every voice IDLE, level 0, phase 0; key_q=0, steal_ptr=0, prescaler=0, sample=0, sample_valid=0, voice_active=0. Reset asserted mid-note clears all state immediately.

## Structure
- synth_pkg holds:
  - voice_state_t (IDLE/ATTACK/SUSTAIN/RELEASE)
  - wave_t
  - INC_TABLE[25]: 16-bit entries, INC[k] = round(f_k·2^16/46875), f_0 = 261.63 Hz, equal temperament
  - waveform encoding constants
- Sub-module poly_voice: phase accumulator, envelope FSM and wave shaper for one voice, with start/retrigger/release controls.
- The allocator, prescaler and mixer stay in poly_synth_core.

## Test plan
- Reset then idle for 600 cycles → sample_valid pulses at cycles 256 and 512, sample=0, voice_active=0.
- Press key 0, saw, octave 0 → voice_active=4'b0001 one cycle later. Level reaches 255 after 16 ticks. Sample at tick n matches the model (p×255>>8)>>2 and stays ≤63.
- Press keys 0–4 in the same cycle → voices 0..3 allocated over 4 cycles. Key 4 steals voice 0 in cycle 5 (phase and level reset). steal_ptr=1; voice_active=4'b1111.
- Release key 0 in SUSTAIN → level falls by 8 per tick and hits 0 at tick 32. voice_active[0] clears on that tick edge.
- Re-press key 0 at level 128 during RELEASE → same voice, phase continuous, ATTACK from 128, reaches 255 at tick 8.
- Assert nRst asynchronously mid-note between clk edges → all outputs 0 immediately. After release, behaviour matches the first scenario.
